// File: rtl/conv_job_ctrl_pkg.sv
// Shared types for the convolution job sequencer.
// Also used by the host/DMA descriptor front end.
package conv_job_ctrl_pkg;

   localparam int DEF_LOG_MAX_ITERS          = 4;
   localparam int DEF_LOG_MAX_READS_PER_ITER = 8;
   localparam int DEF_LOG_MAX_ADDRESS        = 12;

   typedef enum logic [1:0] {
      S_IDLE,
      S_CONFIG,
      S_RUN,
      S_DONE
   } ctrl_state_t;

   typedef struct packed {
      logic [DEF_LOG_MAX_ITERS-1:0]          iters;
      logic [DEF_LOG_MAX_READS_PER_ITER-1:0] reads;
      logic [DEF_LOG_MAX_ADDRESS-1:0]        act_base;
      logic [DEF_LOG_MAX_ADDRESS-1:0]        weight_base;
      logic                                  conf_mode;
   } job_desc_t;

endpackage

// File: rtl/conv_job_ctrl_if.sv
// Job descriptor valid/ready port.
// The host side drives the descriptor, the sequencer returns ready.
interface conv_job_ctrl_if
   import conv_job_ctrl_pkg::*;
#(
   parameter int LOG_MAX_ITERS          = DEF_LOG_MAX_ITERS,
   parameter int LOG_MAX_READS_PER_ITER = DEF_LOG_MAX_READS_PER_ITER,
   parameter int LOG_MAX_ADDRESS        = DEF_LOG_MAX_ADDRESS
);
   logic                              job_valid;
   logic                              job_ready;
   logic [LOG_MAX_ITERS-1:0]          job_num_iters;
   logic [LOG_MAX_READS_PER_ITER-1:0] job_num_reads_per_iter;
   logic [LOG_MAX_ADDRESS-1:0]        job_act_base;
   logic [LOG_MAX_ADDRESS-1:0]        job_weight_base;
   logic                              job_conf_mode;

   modport master (
      output job_valid,
      output job_num_iters,
      output job_num_reads_per_iter,
      output job_act_base,
      output job_weight_base,
      output job_conf_mode,
      input  job_ready
   );

   modport slave (
      input  job_valid,
      input  job_num_iters,
      input  job_num_reads_per_iter,
      input  job_act_base,
      input  job_weight_base,
      input  job_conf_mode,
      output job_ready
   );
endinterface

// File: rtl/conv_job_ctrl_lane.sv
// Per-lane MUL result counter with avail gating.
// Counts up to num_iters, then stops offering avail.
module lane_result_counter #(
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             run,
   input  logic [CNT_W-1:0] num_iters,
   input  logic             valid,
   output logic             avail,
   output logic             beat,
   output logic             lane_done
);
   localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

   logic [CNT_W-1:0] cnt;

   assign avail     = run && (cnt < num_iters);
   assign beat      = valid && avail;
   assign lane_done = (cnt == num_iters)
                   || (beat && ((cnt + ONE) == num_iters));

   // count accepted beats; avail gating keeps cnt <= num_iters
   always_ff @(posedge clk) begin
      if (rst || clear)
         cnt <= '0;
      else if (beat)
         cnt <= cnt + ONE;
   end
endmodule

// File: rtl/conv_job_ctrl.sv
// Job-level sequencer: descriptor slot, configure strobe,
// lane result counting, completion and stall watchdog.
module conv_job_ctrl
   import conv_job_ctrl_pkg::*;
#(
   parameter int LOG_MAX_ITERS          = 4,
   parameter int LOG_MAX_READS_PER_ITER = 8,
   parameter int LOG_MAX_ADDRESS        = 12,
   parameter int NUM_LANES              = 1,
   parameter int TIMEOUT_WIDTH          = 16,
   parameter int JOB_CNT_WIDTH          = 16
) (
   input  logic                              clk,
   input  logic                              rst,
   conv_job_ctrl_if.slave                    job,
   output logic                              configure,
   output logic [LOG_MAX_ITERS-1:0]          num_iters,
   output logic [LOG_MAX_READS_PER_ITER-1:0] num_reads_per_iter,
   output logic [LOG_MAX_ADDRESS-1:0]        act_base_address,
   output logic [LOG_MAX_ADDRESS-1:0]        weight_base_address,
   output logic                              conf_mode,
   input  logic [NUM_LANES-1:0]              result_valid,
   output logic [NUM_LANES-1:0]              result_avail,
   input  logic [TIMEOUT_WIDTH-1:0]          timeout_limit,
   output logic                              busy,
   output logic                              done,
   output logic                              error,
   output logic [JOB_CNT_WIDTH-1:0]          jobs_done
);
   localparam logic [TIMEOUT_WIDTH-1:0] WD_ONE = TIMEOUT_WIDTH'(1);
   localparam logic [JOB_CNT_WIDTH-1:0] JD_ONE = JOB_CNT_WIDTH'(1);

   ctrl_state_t state, state_nxt;

   logic                              pend_full;
   logic                              pend_full_nxt;
   logic [LOG_MAX_ITERS-1:0]          p_iters;
   logic [LOG_MAX_READS_PER_ITER-1:0] p_reads;
   logic [LOG_MAX_ADDRESS-1:0]        p_act;
   logic [LOG_MAX_ADDRESS-1:0]        p_wgt;
   logic                              p_mode;

   logic                     accept, pop;
   logic [NUM_LANES-1:0]     beat, lane_done;
   logic                     all_done, any_beat, wd_hit;
   logic [TIMEOUT_WIDTH-1:0] wd, wd_inc;
   logic                     err_flag;

   assign accept = job.job_valid && job.job_ready;
   assign pop    = (state == S_IDLE) && pend_full;
   assign pend_full_nxt = accept || (pend_full && !pop);

   assign all_done = &lane_done;
   assign any_beat = |beat;
   assign wd_inc   = wd + WD_ONE;
   assign wd_hit   = (timeout_limit != '0) && (wd_inc == timeout_limit);

   for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
      lane_result_counter #(
         .CNT_W (LOG_MAX_ITERS)
      ) u_lane (
         .clk       (clk),
         .rst       (rst),
         .clear     (state == S_CONFIG),
         .run       (state == S_RUN),
         .num_iters (num_iters),
         .valid     (result_valid[l]),
         .avail     (result_avail[l]),
         .beat      (beat[l]),
         .lane_done (lane_done[l])
      );
   end

   // state register
   always_ff @(posedge clk) begin
      if (rst)
         state <= S_IDLE;
      else
         state <= state_nxt;
   end

   // next state and per-state strobes
   always_comb begin
      state_nxt = state;
      configure = 1'b0;
      done      = 1'b0;
      error     = 1'b0;
      busy      = (state != S_IDLE);
      unique case (state)
         S_IDLE: begin
            if (pend_full)
               state_nxt = S_CONFIG;
         end
         S_CONFIG: begin
            configure = 1'b1;
            state_nxt = (num_iters == '0) ? S_DONE : S_RUN;
         end
         S_RUN: begin
            if (all_done || wd_hit)
               state_nxt = S_DONE;
         end
         S_DONE: begin
            done      = 1'b1;
            error     = err_flag;
            state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // pending slot; ready is registered so valid never reaches it
   always_ff @(posedge clk) begin
      if (rst) begin
         pend_full     <= 1'b0;
         job.job_ready <= 1'b0;
         p_iters       <= '0;
         p_reads       <= '0;
         p_act         <= '0;
         p_wgt         <= '0;
         p_mode        <= 1'b0;
      end else begin
         pend_full     <= pend_full_nxt;
         job.job_ready <= !pend_full_nxt;
         if (accept) begin
            p_iters <= job.job_num_iters;
            p_reads <= job.job_num_reads_per_iter;
            p_act   <= job.job_act_base;
            p_wgt   <= job.job_weight_base;
            p_mode  <= job.job_conf_mode;
         end
      end
   end

   // active job config, held until the next pop
   always_ff @(posedge clk) begin
      if (rst) begin
         num_iters           <= '0;
         num_reads_per_iter  <= '0;
         act_base_address    <= '0;
         weight_base_address <= '0;
         conf_mode           <= 1'b0;
      end else if (pop) begin
         num_iters           <= p_iters;
         num_reads_per_iter  <= p_reads;
         act_base_address    <= p_act;
         weight_base_address <= p_wgt;
         conf_mode           <= p_mode;
      end
   end

   // stall watchdog and timeout flag; completion beats timeout
   always_ff @(posedge clk) begin
      if (rst) begin
         wd       <= '0;
         err_flag <= 1'b0;
      end else begin
         err_flag <= (state == S_RUN) && !all_done && wd_hit;
         if (state == S_CONFIG)
            wd <= '0;
         else if (state == S_RUN)
            wd <= any_beat ? '0 : wd_inc;
      end
   end

   // completed-job counter, timeouts included
   always_ff @(posedge clk) begin
      if (rst)
         jobs_done <= '0;
      else if (state == S_DONE)
         jobs_done <= jobs_done + JD_ONE;
   end
endmodule
